// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes decoded RV32I field bundles (class, regs, funct, immediate) back
//   into 32-bit instruction words and streams them into instruction memory
//   starting at BASE_ADDR. Used by the boot/test path to load a program
//   without a hex file.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      pulse: clear count/err and begin a load
//   in_valid/in_ready          field bundle handshake
//   in_class                   0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 JAL, 6 JALR, 7 illegal
//   in_funct3/in_funct7        function fields
//   in_rd/in_rs1/in_rs2        register fields
//   in_imm                     sign-extended byte immediate
//   in_last                    final word of the program
//   mem_we/mem_addr/mem_wdata  memory write request, held until mem_ready
//   mem_ready                  memory accepts the write this cycle
//   busy, done, err            status (err is sticky until start)
//   word_count                 words written since start
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_WORDS  = 128,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-2:0] word_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-2:0] MAX_CNT = (ADDR_WIDTH-1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_last;
    logic [ADDR_WIDTH-2:0] r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    logic [31:0]           w_enc;
    logic                  w_legal;
    logic [ADDR_WIDTH-2:0] w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [11:0]           w_imm_i;
    logic                  w_unused;

    // Immediate bits above every format's field are dropped by design.
    assign w_unused  = ^in_imm[31:21];

    assign w_legal   = (in_class != 3'd7);
    assign w_cnt_inc = r_count + 1'b1;
    assign w_addr    = BASE + {r_count[ADDR_WIDTH-3:0], 2'b00};

    // Shift-immediate variants carry funct7 in the upper immediate bits.
    always_comb begin
        w_imm_i = in_imm[11:0];
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
            w_imm_i = {in_funct7, in_imm[4:0]};
    end

    always_comb begin
        w_enc = 32'h0;
        case (in_class)
            3'd0: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: w_enc = {w_imm_i, in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd2: w_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            3'd3: w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            3'd4: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], 7'b1100011};
            3'd5: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, 7'b1101111};
            3'd6: w_enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            default: w_enc = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
            r_count    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCEPT;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_mem_we   <= 1'b1;
                            r_wdata    <= w_enc;
                            r_addr     <= w_addr;
                            r_last     <= in_last;
                        end else begin
                            // Illegal bundle is consumed; only its in_last matters.
                            r_err <= 1'b1;
                            if (in_last) begin
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_we <= 1'b0;
                        r_count  <= w_cnt_inc;
                        // Filling the region ends the load even without in_last.
                        if (r_last || w_cnt_inc == MAX_CNT) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state    <= S_ACCEPT;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_count;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: takes decoded instruction fields (format class, registers, funct, immediate) and encodes them into 32-bit RV32I words.
- Writes the encoded words sequentially into instruction memory through a write port with backpressure.
- Used by the test/boot path to load programs without a hex file.
- Supports exactly the opcode set the core decodes: R-type, I-type ALU, LW, SW, branch, JAL, JALR.

Parameters:
- ADDR_WIDTH, 9, byte-address width of mem_addr.
- MAX_WORDS, 128, word capacity of the load region (1..2^(ADDR_WIDTH-2)).
- BASE_ADDR, 0, byte address of the first word; must be word-aligned.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear count/err and begin a load
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_class  in  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 JAL, 6 JALR, 7 illegal
- in_funct3  in  3  funct3; ignored for LW/SW (forced 010), JALR (forced 000), JAL
- in_funct7  in  7  funct7 for R and I-shift (funct3 001/101)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  sign-extended byte immediate
- in_last  in  1  final word of the program
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH  byte address = BASE_ADDR + 4*count
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts the write this cycle when mem_we=1
- busy  out  1  high in ACCEPT and WRITE
- done  out  1  high in DONE
- err  out  1  sticky: an illegal class was received
- word_count  out  ADDR_WIDTH-1  words written since start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; count 0; any in-flight write is dropped.
- States:
  - IDLE: start -> ACCEPT.
  - ACCEPT: in_ready=1; on in_valid & legal class -> WRITE; on class 7, consume the bundle, set err, stay in ACCEPT (no write, count unchanged); if that bundle has in_last=1 -> DONE.
  - WRITE: mem_we=1; mem_addr/mem_wdata held stable until mem_ready=1. On that cycle count+1, then -> DONE if in_last was set or count+1==MAX_WORDS, else -> ACCEPT.
  - DONE: done=1 until start -> ACCEPT (count, err cleared).
- Handshake and latency:
  - Handshake occurs when in_valid & in_ready.
  - Encoding is registered on the handshake edge; mem_we rises the next cycle.
  - With mem_ready tied high, one word is written every 2 cycles.
- start is ignored in ACCEPT/WRITE. start in DONE restarts and overwrites from BASE_ADDR.
- Encoding (opcode [6:0]):
  - R: 0110011; {funct7, rs2, rs1, funct3, rd, op}.
  - I-ALU: 0010011; imm[11:0] in [31:20]; for funct3 001/101, [31:25]=funct7 and [24:20]=imm[4:0].
  - LW: 0000011; I-format, funct3 010.
  - JALR: 1100111; I-format, funct3 000.
  - SW: 0100011; [31:25]=imm[11:5], [11:7]=imm[4:0], funct3 010.
  - BR: 1100011; [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - JAL: 1101111; [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd in [11:7].
- Immediate bits outside each format's field are discarded without error. imm[0] is ignored for BR/JAL.
- word_count saturates at MAX_WORDS. Reaching MAX_WORDS forces DONE even without in_last; no further writes occur.

Test Plan:
- Reset, start, LW rd=5 rs1=1 imm=4 with mem_ready=1 -> mem_we high 1 cycle after handshake; mem_addr=0, mem_wdata=0x0040A283; word_count=1.
- Stream addi x1,x0,5; add x3,x1,x2 (funct7=0); sw x2,8(x1) -> words 0x00500093, 0x002081B3, 0x0020A423 at addresses 0, 4, 8; in_ready low during each WRITE.
- beq x1,x2,+8 then jal x1,+16 with in_last=1, mem_ready held low 3 cycles on the first write -> 0x00208463 held stable until accepted, then 0x010000EF; done=1, busy=0.
- class 7 bundle mid-stream -> err=1, no mem_we, next legal word lands at the next address; start clears err and count.
- MAX_WORDS=2, three bundles offered -> two writes, done after the second; third bundle not accepted (in_ready=0).
- rst_n low during WRITE with mem_ready=0 -> mem_we, busy, done, err, and word_count all 0 immediately (asynchronous), state IDLE.
